// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
//   UART_DATA_W          byte width of the UART datapath
//   DEFAULT_TIMEOUT_CYC  default watchdog limit for one transfer, in clk cycles
//   tx_arb_state_e       arbiter FSM state encoding
package uart_pkg;

  localparam int unsigned UART_DATA_W         = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 10000;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StStart    = 2'd1,
    StWaitDone = 2'd2
  } tx_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection.
//   req      per-requester request level
//   last     index of the previous winner; search starts at last+1
//   gnt      onehot winner (all zero when req is zero)
//   gnt_idx  binary index of the winner
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic            found;
  int unsigned     cand;
  logic [PTR_W-1:0] cand_idx;

  // Walk last+1, last+2, ... modulo NUM_REQ (rotate, priority-encode, rotate back).
  // The modulo keeps the wrap correct when NUM_REQ is not a power of two.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(last) + i) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte requesters with round-robin fairness.
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   req          per-requester request level
//   req_data     requester i byte at [i*DATA_W +: DATA_W]
//   gnt          one-cycle onehot pulse: byte of requester i accepted
//   grant_id     index of requester owning the transmitter
//   busy         high whenever a transfer is in progress
//   tx_start     one-cycle start pulse to the transmitter
//   tx_data      byte to the transmitter, stable from gnt until next grant
//   tx_done      transmitter completion (pulse or level, rising edge used)
//   timeout_err  one-cycle pulse when the watchdog aborts a transfer
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned DATA_W      = UART_DATA_W,
  parameter  int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter  int unsigned TO_W        = 16,
  localparam int unsigned PTR_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [PTR_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_done,
  output logic                      timeout_err
);

  tx_arb_state_e       state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]    grant_id_q, grant_id_d;
  logic [PTR_W-1:0]    last_q, last_d;
  logic                busy_q, busy_d;
  logic                tx_start_q, tx_start_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                timeout_err_q, timeout_err_d;
  logic [TO_W-1:0]     count_q, count_d;
  logic                done_q;

  logic [NUM_REQ-1:0]  win_gnt;
  logic [PTR_W-1:0]    win_idx;
  logic [DATA_W-1:0]   win_data;
  logic                done_edge;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req),
    .last    (last_q),
    .gnt     (win_gnt),
    .gnt_idx (win_idx)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_gnt[i]) win_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // done_q tracks tx_done in every state, so a level already high when WAIT_DONE
  // is entered is never mistaken for a fresh completion.
  assign done_edge = tx_done & ~done_q;

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    grant_id_d    = grant_id_q;
    last_d        = last_q;
    busy_d        = busy_q;
    tx_start_d    = tx_start_q;
    tx_data_d     = tx_data_q;
    timeout_err_d = 1'b0;
    count_d       = count_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          tx_data_d  = win_data;
          gnt_d      = win_gnt;
          grant_id_d = win_idx;
          last_d     = win_idx;
          busy_d     = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        gnt_d      = '0;
        tx_start_d = 1'b1;
        count_d    = '0;
        state_d    = StWaitDone;
      end
      StWaitDone: begin
        tx_start_d = 1'b0;
        if (done_edge) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (count_q == TO_W'(TIMEOUT_CYC - 1)) begin
          // Aborted winner keeps the pointer: it loses its slot rather than retrying.
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = StIdle;
        end else begin
          count_d = count_q + TO_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      gnt_q         <= '0;
      grant_id_q    <= '0;
      last_q        <= PTR_W'(NUM_REQ - 1);
      busy_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      timeout_err_q <= 1'b0;
      count_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      grant_id_q    <= grant_id_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      timeout_err_q <= timeout_err_d;
      count_q       <= count_d;
      done_q        <= tx_done;
    end
  end

  assign gnt         = gnt_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; the transmitter is modelled by driving tx_done
// and capturing tx_data when tx_start pulses (loopback equivalent).
module tb_uart_tx_arbiter;

  localparam int unsigned NumReq  = 4;
  localparam int unsigned DataW   = 8;
  localparam int unsigned Timeout = 100;

  logic                    clk;
  logic                    reset;
  logic [NumReq-1:0]       req;
  logic [NumReq*DataW-1:0] req_data;
  logic [NumReq-1:0]       gnt;
  logic [1:0]              grant_id;
  logic                    busy;
  logic                    tx_start;
  logic [DataW-1:0]        tx_data;
  logic                    tx_done;
  logic                    timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [DataW-1:0] rx_byte;

  uart_tx_arbiter #(
    .NUM_REQ     (NumReq),
    .DATA_W      (DataW),
    .TIMEOUT_CYC (Timeout),
    .TO_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .grant_id    (grant_id),
    .busy        (busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer, assuming the grant happens at the next edge.
  task automatic xfer(input int id, input logic [7:0] data, input bit drop, input int lat);
    tick();
    check("gnt", 32'(gnt), 32'(1) << id);
    check("grant_id", 32'(grant_id), 32'(id));
    check("tx_data", 32'(tx_data), 32'(data));
    check("busy_grant", 32'(busy), 1);
    check("tx_start_pre", 32'(tx_start), 0);
    if (drop) req[id] = 1'b0;
    tick();
    check("gnt_clear", 32'(gnt), 0);
    check("tx_start", 32'(tx_start), 1);
    rx_byte = tx_data;
    check("rx_byte", 32'(rx_byte), 32'(data));
    tick();
    check("tx_start_one", 32'(tx_start), 0);
    repeat (lat) tick();
    check("busy_wait", 32'(busy), 1);
    tx_done = 1'b1;
    tick();
    check("busy_done", 32'(busy), 0);
    check("no_timeout", 32'(timeout_err), 0);
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation bound reached, expected finish earlier");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_data = {8'h5A, 8'hFF, 8'h3C, 8'hA5};
    tx_done  = 1'b0;
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    reset = 1'b1;

    // Contention: all four requesting, each dropped after its grant.
    req = 4'b1111;
    xfer(0, 8'hA5, 1'b1, 3);
    xfer(1, 8'h3C, 1'b1, 3);
    xfer(2, 8'hFF, 1'b1, 3);
    xfer(3, 8'h5A, 1'b1, 3);
    tick();
    check("contention_no_extra", 32'(gnt), 0);
    check("contention_idle", 32'(busy), 0);

    // Single requester after pointer wrapped to 3.
    req = 4'b0001;
    xfer(0, 8'hA5, 1'b1, 5);

    // Fairness: requesters 1 and 3 held for six transfers.
    req = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) xfer(1, 8'h3C, 1'b0, 2);
      else            xfer(3, 8'h5A, 1'b0, 2);
    end
    req = '0;
    tick();
    check("fair_idle", 32'(busy), 0);

    // Timeout: tx_done never rises.
    req = 4'b0100;
    tick();
    check("to_gnt", 32'(gnt), 32'b0100);
    req = '0;
    tick();
    check("to_tx_start", 32'(tx_start), 1);
    repeat (Timeout - 1) tick();
    check("to_not_yet", 32'(timeout_err), 0);
    check("to_busy_before", 32'(busy), 1);
    tick();
    check("to_err", 32'(timeout_err), 1);
    check("to_busy_after", 32'(busy), 0);
    tick();
    check("to_err_pulse", 32'(timeout_err), 0);
    // Pointer stays at 2, so 3 beats 1.
    req = 4'b1010;
    xfer(3, 8'h5A, 1'b1, 2);
    req = '0;
    tick();

    // Stale tx_done level before the grant.
    tx_done = 1'b1;
    req = 4'b0001;
    tick();
    check("stale_gnt", 32'(gnt), 32'b0001);
    req = '0;
    repeat (7) tick();
    check("stale_busy", 32'(busy), 1);
    tx_done = 1'b0;
    tick();
    check("stale_busy_low", 32'(busy), 1);
    tx_done = 1'b1;
    tick();
    check("stale_fresh_edge", 32'(busy), 0);
    tx_done = 1'b0;
    tick();

    // Reset during START: tx_start drops asynchronously.
    req = 4'b0100;
    tick();
    check("mid_gnt", 32'(gnt), 32'b0100);
    tick();
    check("mid_tx_start", 32'(tx_start), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_tx_start", 32'(tx_start), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_grant_id", 32'(grant_id), 0);
    req_data[23:16] = 8'h3C;
    req = 4'b0101;
    tick();
    reset = 1'b1;
    xfer(0, 8'hA5, 1'b1, 2);
    xfer(2, 8'h3C, 1'b1, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
